// File: rtl/multi_branch_unit.sv
// Multi-lane branch resolution unit: NR_LANES control-flow ops per cycle, one register stage.
// Optional build macro BRANCH_UNIT_STATS_EN adds saturating branch/mispredict counters.

module multi_branch_unit_lane #(
  parameter int VLEN = 39,
  parameter int RVC  = 1
) (
  input  logic [1:0]      op_i,
  input  logic [VLEN-1:0] pc_i,
  input  logic [VLEN-1:0] base_i,
  input  logic [VLEN-1:0] imm_i,
  input  logic            is_compressed_i,
  input  logic            comp_res_i,
  input  logic [2:0]      pred_cf_i,
  input  logic [VLEN-1:0] pred_addr_i,
  output logic [VLEN-1:0] next_pc_o,
  output logic [VLEN-1:0] target_o,
  output logic            taken_o,
  output logic            mispredict_o,
  output logic            ex_o,
  output logic [2:0]      cf_o,
  output logic            is_res_o
);
  localparam logic [2:0] CF_NONE = 3'd0, CF_BRANCH = 3'd1, CF_JUMPR = 3'd3, CF_RET = 3'd4;

  logic            is_br, is_jalr;
  logic [VLEN-1:0] sum;

  always_comb begin
    is_br     = (op_i == 2'd0);
    is_jalr   = (op_i == 2'd2);
    next_pc_o = pc_i + (is_compressed_i ? VLEN'(2) : VLEN'(4));
    sum       = (is_jalr ? base_i : pc_i) + imm_i;
    target_o  = is_jalr ? {sum[VLEN-1:1], 1'b0} : sum;
    taken_o   = is_br ? comp_res_i : 1'b1;
    if (is_br)
      mispredict_o = comp_res_i != (pred_cf_i == CF_BRANCH);
    else if (is_jalr)
      mispredict_o = (pred_cf_i == CF_NONE) || (target_o != pred_addr_i);
    else
      mispredict_o = 1'b0;
    ex_o = taken_o && (target_o[0] || ((RVC == 0) && target_o[1]));
    if (is_br)
      cf_o = CF_BRANCH;
    else if (is_jalr && mispredict_o && pred_cf_i != CF_RET)
      cf_o = CF_JUMPR;
    else
      cf_o = pred_cf_i;
    is_res_o = is_br | is_jalr;
  end
endmodule

module multi_branch_unit #(
  parameter int NR_LANES   = 2,
  parameter int VLEN       = 39,
  parameter int TRANS_ID_W = 3,
  parameter int RVC        = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  output logic                         in_ready_o,
  input  logic [NR_LANES-1:0]          valid_i,
  input  logic [NR_LANES*2-1:0]        op_i,
  input  logic [NR_LANES*VLEN-1:0]     pc_i,
  input  logic [NR_LANES*VLEN-1:0]     base_i,
  input  logic [NR_LANES*VLEN-1:0]     imm_i,
  input  logic [NR_LANES-1:0]          is_compressed_i,
  input  logic [NR_LANES-1:0]          comp_res_i,
  input  logic [NR_LANES*3-1:0]        pred_cf_i,
  input  logic [NR_LANES*VLEN-1:0]     pred_addr_i,
  input  logic [NR_LANES*TRANS_ID_W-1:0] trans_id_i,
  output logic [NR_LANES-1:0]          result_valid_o,
  output logic [NR_LANES*VLEN-1:0]     result_o,
  output logic [NR_LANES*TRANS_ID_W-1:0] trans_id_o,
  output logic [NR_LANES-1:0]          ex_valid_o,
  output logic [NR_LANES*VLEN-1:0]     ex_tval_o,
  output logic                         resolved_valid_o,
  output logic [VLEN-1:0]              resolved_pc_o,
  output logic [VLEN-1:0]              resolved_target_o,
  output logic                         resolved_taken_o,
  output logic                         resolved_mispredict_o,
  output logic [2:0]                   resolved_cf_o
`ifdef BRANCH_UNIT_STATS_EN
  ,
  output logic [31:0]                  stat_branches_o,
  output logic [31:0]                  stat_mispredicts_o
`endif
);
  localparam int LW = (NR_LANES > 1) ? $clog2(NR_LANES) : 1;

  typedef enum logic {S_RUN, S_SQUASH} state_e;
  state_e state_q, state_d;

  logic [NR_LANES-1:0][VLEN-1:0] pc_arr, next_pc, target;
  logic [NR_LANES-1:0][2:0]      cf;
  logic [NR_LANES-1:0]           taken, mis, ex, is_res;

  logic                accept, found, res_any;
  logic [NR_LANES-1:0] lane_vld, evt, squash;
  logic [LW-1:0]       evt_idx, res_idx;
  logic                res_valid_d, res_mis_d;

  logic [NR_LANES-1:0]                result_valid_q, ex_valid_q;
  logic [NR_LANES-1:0][VLEN-1:0]      result_q;
  logic [NR_LANES*TRANS_ID_W-1:0]     trans_id_q;
  logic [NR_LANES*VLEN-1:0]           ex_tval_q;
  logic                               res_valid_q, res_mis_q, res_taken_q;
  logic [VLEN-1:0]                    res_pc_q, res_target_q;
  logic [2:0]                         res_cf_q;

  assign pc_arr = pc_i;

  for (genvar l = 0; l < NR_LANES; l++) begin : g_lane
    multi_branch_unit_lane #(.VLEN(VLEN), .RVC(RVC)) u_lane (
      .op_i           (op_i[2*l +: 2]),
      .pc_i           (pc_i[VLEN*l +: VLEN]),
      .base_i         (base_i[VLEN*l +: VLEN]),
      .imm_i          (imm_i[VLEN*l +: VLEN]),
      .is_compressed_i(is_compressed_i[l]),
      .comp_res_i     (comp_res_i[l]),
      .pred_cf_i      (pred_cf_i[3*l +: 3]),
      .pred_addr_i    (pred_addr_i[VLEN*l +: VLEN]),
      .next_pc_o      (next_pc[l]),
      .target_o       (target[l]),
      .taken_o        (taken[l]),
      .mispredict_o   (mis[l]),
      .ex_o           (ex[l]),
      .cf_o           (cf[l]),
      .is_res_o       (is_res[l])
    );
  end

  // Oldest event lane wins; everything younger is squashed and it owns the frontend port.
  always_comb begin
    accept   = (state_q == S_RUN) && !flush_i;
    lane_vld = valid_i & {NR_LANES{accept}};
    evt      = lane_vld & (mis | ex);
    found    = 1'b0;
    evt_idx  = '0;
    squash   = '0;
    res_any  = 1'b0;
    res_idx  = '0;
    for (int l = 0; l < NR_LANES; l++) begin
      if (found) squash[l] = 1'b1;
      else if (evt[l]) begin
        found   = 1'b1;
        evt_idx = LW'(l);
      end
    end
    for (int l = NR_LANES - 1; l >= 0; l--) begin
      if (lane_vld[l] && is_res[l]) begin
        res_any = 1'b1;
        res_idx = LW'(l);
      end
    end
    if (found) res_idx = evt_idx;
    res_valid_d = found | res_any;
    res_mis_d   = res_valid_d & mis[res_idx];
  end

  always_comb begin
    state_d    = state_q;
    in_ready_o = 1'b0;
    case (state_q)
      S_RUN: begin
        in_ready_o = 1'b1;
        if (!flush_i && found) state_d = S_SQUASH;
      end
      S_SQUASH: if (flush_i) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_RUN;
    else         state_q <= state_d;
  end

  // Valid-class flops follow every cycle; data flops only move on accepted cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_valid_q <= '0;
      ex_valid_q     <= '0;
      res_valid_q    <= 1'b0;
      res_mis_q      <= 1'b0;
      result_q       <= '0;
      trans_id_q     <= '0;
      ex_tval_q      <= '0;
      res_pc_q       <= '0;
      res_target_q   <= '0;
      res_taken_q    <= 1'b0;
      res_cf_q       <= '0;
    end else begin
      result_valid_q <= lane_vld & ~squash;
      ex_valid_q     <= lane_vld & ex & ~squash;
      res_valid_q    <= res_valid_d;
      res_mis_q      <= res_mis_d;
      if (accept) begin
        result_q     <= next_pc;
        trans_id_q   <= trans_id_i;
        ex_tval_q    <= pc_i;
        res_pc_q     <= pc_arr[res_idx];
        res_target_q <= taken[res_idx] ? target[res_idx] : next_pc[res_idx];
        res_taken_q  <= taken[res_idx];
        res_cf_q     <= cf[res_idx];
      end
    end
  end

  assign result_valid_o        = result_valid_q;
  assign result_o              = result_q;
  assign trans_id_o            = trans_id_q;
  assign ex_valid_o            = ex_valid_q;
  assign ex_tval_o             = ex_tval_q;
  assign resolved_valid_o      = res_valid_q;
  assign resolved_pc_o         = res_pc_q;
  assign resolved_target_o     = res_target_q;
  assign resolved_taken_o      = res_taken_q;
  assign resolved_mispredict_o = res_mis_q;
  assign resolved_cf_o         = res_cf_q;

`ifdef BRANCH_UNIT_STATS_EN
  logic [31:0] br_cnt_q, mis_cnt_q;
  logic [32:0] br_sum;

  always_comb begin
    br_sum = {1'b0, br_cnt_q};
    for (int l = 0; l < NR_LANES; l++)
      br_sum = br_sum + 33'(lane_vld[l] & ~squash[l]);
  end

  // Flush deliberately leaves the counters alone; only reset clears them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_sum[32] ? '1 : br_sum[31:0];
      if (res_mis_q && mis_cnt_q != '1) mis_cnt_q <= mis_cnt_q + 32'd1;
    end
  end

  assign stat_branches_o    = br_cnt_q;
  assign stat_mispredicts_o = mis_cnt_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_multi_branch_unit.sv
// Directed scoreboard bench for multi_branch_unit; a second instance runs with RVC=0.
module tb_multi_branch_unit;
  localparam int NL = 2, VL = 39, TW = 3;

  logic clk = 1'b0, rst_n, flush;
  logic [NL-1:0] valid, isc, comp;
  logic [NL*2-1:0] op;
  logic [NL*VL-1:0] pc, base, imm, paddr;
  logic [NL*3-1:0] pcf;
  logic [NL*TW-1:0] tid;

  logic rdy, resv, rtaken, rmis, rdy0, resv0, rtaken0, rmis0;
  logic [NL-1:0] rv, exv, rv0, exv0;
  logic [NL*VL-1:0] res, tval, res0, tval0;
  logic [NL*TW-1:0] tido, tido0;
  logic [VL-1:0] rpc, rtgt, rpc0, rtgt0;
  logic [2:0] rcf, rcf0;
`ifdef BRANCH_UNIT_STATS_EN
  logic [31:0] sb, sm, sb0, sm0;
`endif

  always #5 clk = ~clk;

  multi_branch_unit #(.NR_LANES(NL), .VLEN(VL), .TRANS_ID_W(TW), .RVC(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_ready_o(rdy), .valid_i(valid),
    .op_i(op), .pc_i(pc), .base_i(base), .imm_i(imm), .is_compressed_i(isc),
    .comp_res_i(comp), .pred_cf_i(pcf), .pred_addr_i(paddr), .trans_id_i(tid),
    .result_valid_o(rv), .result_o(res), .trans_id_o(tido), .ex_valid_o(exv),
    .ex_tval_o(tval), .resolved_valid_o(resv), .resolved_pc_o(rpc),
    .resolved_target_o(rtgt), .resolved_taken_o(rtaken),
    .resolved_mispredict_o(rmis), .resolved_cf_o(rcf)
`ifdef BRANCH_UNIT_STATS_EN
    , .stat_branches_o(sb), .stat_mispredicts_o(sm)
`endif
  );

  multi_branch_unit #(.NR_LANES(NL), .VLEN(VL), .TRANS_ID_W(TW), .RVC(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_ready_o(rdy0), .valid_i(valid),
    .op_i(op), .pc_i(pc), .base_i(base), .imm_i(imm), .is_compressed_i(isc),
    .comp_res_i(comp), .pred_cf_i(pcf), .pred_addr_i(paddr), .trans_id_i(tid),
    .result_valid_o(rv0), .result_o(res0), .trans_id_o(tido0), .ex_valid_o(exv0),
    .ex_tval_o(tval0), .resolved_valid_o(resv0), .resolved_pc_o(rpc0),
    .resolved_target_o(rtgt0), .resolved_taken_o(rtaken0),
    .resolved_mispredict_o(rmis0), .resolved_cf_o(rcf0)
`ifdef BRANCH_UNIT_STATS_EN
    , .stat_branches_o(sb0), .stat_mispredicts_o(sm0)
`endif
  );

  typedef struct {
    string tag;
    logic [1:0] rv, exv, exv0;
    logic rdy, rdy0, resv, rtaken, rmis;
    logic [VL-1:0] res0, tval0, tval1, tval00, rpc, rtgt;
    logic [TW-1:0] tid0;
    logic [2:0] rcf;
  } exp_t;

  exp_t q[$];
  exp_t e, cur;
  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] x);
    total++;
    assert (o === x) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, o, x);
    end
  endtask

  task automatic clr();
    valid = '0; flush = 1'b0; op = '0; pc = '0; base = '0; imm = '0;
    isc = '0; comp = '0; pcf = '0; paddr = '0; tid = '0;
  endtask

  task automatic lane(input int l, input logic [1:0] o, input logic [VL-1:0] p, input logic [VL-1:0] b,
                      input logic [VL-1:0] i, input logic c, input logic cr, input logic [2:0] pf,
                      input logic [VL-1:0] pa, input logic [TW-1:0] t);
    valid[l] = 1'b1; op[l*2 +: 2] = o; pc[l*VL +: VL] = p; base[l*VL +: VL] = b;
    imm[l*VL +: VL] = i; isc[l] = c; comp[l] = cr; pcf[l*3 +: 3] = pf;
    paddr[l*VL +: VL] = pa; tid[l*TW +: TW] = t;
  endtask

  task automatic expect_(input string tag, input logic [1:0] rv_, input logic [1:0] exv_,
                         input logic rdy_, input logic [1:0] exv0_, input logic rdy0_);
    e.tag = tag; e.rv = rv_; e.exv = exv_; e.rdy = rdy_; e.exv0 = exv0_; e.rdy0 = rdy0_;
    e.resv = 1'b0; e.rtaken = 1'b0; e.rmis = 1'b0; e.res0 = '0; e.tval0 = '0;
    e.tval1 = '0; e.tval00 = '0; e.rpc = '0; e.rtgt = '0; e.tid0 = '0; e.rcf = '0;
  endtask

  task automatic exp_res(input logic [VL-1:0] p, input logic [VL-1:0] t, input logic tk,
                         input logic m, input logic [2:0] c);
    e.resv = 1'b1; e.rpc = p; e.rtgt = t; e.rtaken = tk; e.rmis = m; e.rcf = c;
  endtask

  task automatic push();
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      total++; bad++;
      $error("FAIL sb_empty: got 0 entries want 1");
    end else begin
      cur = q.pop_front();
      chk({cur.tag, ".rv"}, 64'(rv), 64'(cur.rv));
      chk({cur.tag, ".exv"}, 64'(exv), 64'(cur.exv));
      chk({cur.tag, ".rdy"}, 64'(rdy), 64'(cur.rdy));
      chk({cur.tag, ".resv"}, 64'(resv), 64'(cur.resv));
      chk({cur.tag, ".exv_rvc0"}, 64'(exv0), 64'(cur.exv0));
      chk({cur.tag, ".rdy_rvc0"}, 64'(rdy0), 64'(cur.rdy0));
      if (cur.rv[0]) begin
        chk({cur.tag, ".res0"}, 64'(res[VL-1:0]), 64'(cur.res0));
        chk({cur.tag, ".tid0"}, 64'(tido[TW-1:0]), 64'(cur.tid0));
      end
      if (cur.exv[0]) chk({cur.tag, ".tval0"}, 64'(tval[VL-1:0]), 64'(cur.tval0));
      if (cur.exv[1]) chk({cur.tag, ".tval1"}, 64'(tval[2*VL-1:VL]), 64'(cur.tval1));
      if (cur.exv0[0]) chk({cur.tag, ".tval_rvc0"}, 64'(tval0[VL-1:0]), 64'(cur.tval00));
      if (cur.resv) begin
        chk({cur.tag, ".rpc"}, 64'(rpc), 64'(cur.rpc));
        chk({cur.tag, ".rtgt"}, 64'(rtgt), 64'(cur.rtgt));
        chk({cur.tag, ".rtaken"}, 64'(rtaken), 64'(cur.rtaken));
        chk({cur.tag, ".rmis"}, 64'(rmis), 64'(cur.rmis));
        chk({cur.tag, ".rcf"}, 64'(rcf), 64'(cur.rcf));
      end
    end
    clr();
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.rdy", 64'(rdy), 64'd1);
    chk("rst.rv", 64'(rv), 64'd0);
    chk("rst.resv", 64'(resv), 64'd0);
    chk("rst.res", 64'(res[VL-1:0]), 64'd0);
    chk("rst.rtgt", 64'(rtgt), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // predicted-taken branch resolves correctly
    lane(0, 2'd0, 39'h1000, 39'h0, 39'h40, 1'b0, 1'b1, 3'd1, 39'h1040, 3'd5);
    expect_("br_ok", 2'b01, 2'b00, 1'b1, 2'b00, 1'b1); e.res0 = 39'h1004; e.tid0 = 3'd5;
    exp_res(39'h1000, 39'h1040, 1'b1, 1'b0, 3'd1); push(); step();

    // JAL + not-taken branch on lane1: lane1 is the resolution source
    lane(0, 2'd1, 39'h2000, 39'h0, 39'h10, 1'b1, 1'b0, 3'd2, 39'h2010, 3'd1);
    lane(1, 2'd0, 39'h2002, 39'h0, 39'h7F_FFFF_FFF8, 1'b0, 1'b0, 3'd0, 39'h0, 3'd2);
    expect_("two_lane", 2'b11, 2'b00, 1'b1, 2'b00, 1'b1); e.res0 = 39'h2002; e.tid0 = 3'd1;
    exp_res(39'h2002, 39'h2006, 1'b0, 1'b0, 3'd1); push(); step();

    // JALR with NoCF prediction mispredicts; RVC=0 instance also faults on bit 1
    lane(0, 2'd2, 39'h3000, 39'h2003, 39'h0, 1'b0, 1'b0, 3'd0, 39'h0, 3'd3);
    expect_("jalr_mis", 2'b01, 2'b00, 1'b0, 2'b01, 1'b0); e.res0 = 39'h3004; e.tid0 = 3'd3;
    e.tval00 = 39'h3000; exp_res(39'h3000, 39'h2002, 1'b1, 1'b1, 3'd3); push(); step();

    lane(0, 2'd0, 39'h5000, 39'h0, 39'h4, 1'b0, 1'b1, 3'd1, 39'h5004, 3'd0);
    expect_("squash_ign0", 2'b00, 2'b00, 1'b0, 2'b00, 1'b0); push(); step();
    lane(1, 2'd2, 39'h5004, 39'h100, 39'h0, 1'b0, 1'b0, 3'd0, 39'h0, 3'd0);
    expect_("squash_ign1", 2'b00, 2'b00, 1'b0, 2'b00, 1'b0); push(); step();

    flush = 1'b1;
    lane(0, 2'd0, 39'h6000, 39'h0, 39'h4, 1'b0, 1'b1, 3'd1, 39'h6004, 3'd0);
    expect_("flush_sq", 2'b00, 2'b00, 1'b1, 2'b00, 1'b1); push(); step();

    // branch mispredict on lane0 squashes the younger JAL
    lane(0, 2'd0, 39'h4000, 39'h0, 39'h80, 1'b0, 1'b0, 3'd1, 39'h4080, 3'd4);
    lane(1, 2'd1, 39'h4004, 39'h0, 39'h8, 1'b0, 1'b0, 3'd2, 39'h400C, 3'd5);
    expect_("br_mis_sq", 2'b01, 2'b00, 1'b0, 2'b00, 1'b0); e.res0 = 39'h4004; e.tid0 = 3'd4;
    exp_res(39'h4000, 39'h4004, 1'b0, 1'b1, 3'd1); push(); step();

    flush = 1'b1;
    expect_("flush1", 2'b00, 2'b00, 1'b1, 2'b00, 1'b1); push(); step();

    // flush in RUN drops the presented lane
    flush = 1'b1;
    lane(0, 2'd0, 39'h1000, 39'h0, 39'h40, 1'b0, 1'b1, 3'd1, 39'h1040, 3'd2);
    expect_("flush_run", 2'b00, 2'b00, 1'b1, 2'b00, 1'b1); push(); step();

    lane(0, 2'd1, 39'h100, 39'h0, 39'h2, 1'b0, 1'b0, 3'd2, 39'h102, 3'd6);
    expect_("jal_102", 2'b01, 2'b00, 1'b1, 2'b01, 1'b0); e.res0 = 39'h104; e.tid0 = 3'd6;
    e.tval00 = 39'h100; push(); step();

    flush = 1'b1;
    expect_("flush2", 2'b00, 2'b00, 1'b1, 2'b00, 1'b1); push(); step();

    lane(0, 2'd1, 39'h7F_FFFF_FFFE, 39'h0, 39'h10, 1'b1, 1'b0, 3'd2, 39'hE, 3'd7);
    expect_("wrap", 2'b01, 2'b00, 1'b1, 2'b01, 1'b0); e.res0 = 39'h0; e.tid0 = 3'd7;
    e.tval00 = 39'h7F_FFFF_FFFE; push(); step();

    flush = 1'b1;
    expect_("flush3", 2'b00, 2'b00, 1'b1, 2'b00, 1'b1); push(); step();

    // odd JAL target on lane1 is the event; lane0 branch not taken, correctly predicted
    lane(0, 2'd0, 39'h500, 39'h0, 39'h20, 1'b0, 1'b0, 3'd0, 39'h0, 3'd1);
    lane(1, 2'd1, 39'h504, 39'h0, 39'h3, 1'b0, 1'b0, 3'd2, 39'h0, 3'd6);
    expect_("ex_lane1", 2'b11, 2'b10, 1'b0, 2'b10, 1'b0); e.res0 = 39'h504; e.tid0 = 3'd1;
    e.tval1 = 39'h504; exp_res(39'h504, 39'h507, 1'b1, 1'b0, 3'd2); push(); step();

    flush = 1'b1;
    expect_("flush4", 2'b00, 2'b00, 1'b1, 2'b00, 1'b1); push(); step();

    lane(0, 2'd2, 39'h600, 39'h800, 39'h20, 1'b0, 1'b0, 3'd3, 39'h820, 3'd2);
    expect_("jalr_ok", 2'b01, 2'b00, 1'b1, 2'b00, 1'b1); e.res0 = 39'h604; e.tid0 = 3'd2;
    exp_res(39'h600, 39'h820, 1'b1, 1'b0, 3'd3); push(); step();

    lane(0, 2'd2, 39'h700, 39'h900, 39'h0, 1'b1, 1'b0, 3'd4, 39'h904, 3'd3);
    expect_("jalr_ret", 2'b01, 2'b00, 1'b0, 2'b00, 1'b0); e.res0 = 39'h702; e.tid0 = 3'd3;
    exp_res(39'h700, 39'h900, 1'b1, 1'b1, 3'd4); push(); step();

    // asynchronous reset while in SQUASH
    #2 rst_n = 1'b0;
    #1;
    chk("arst.rdy", 64'(rdy), 64'd1);
    chk("arst.rv", 64'(rv), 64'd0);
    chk("arst.rmis", 64'(rmis), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    lane(0, 2'd1, 39'h10, 39'h0, 39'h20, 1'b0, 1'b0, 3'd2, 39'h30, 3'd4);
    expect_("post_arst", 2'b01, 2'b00, 1'b1, 2'b00, 1'b1); e.res0 = 39'h14; e.tid0 = 3'd4;
    push(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multi_branch_unit.md
Name: multi_branch_unit

Overview:
Multi-lane successor to the single-lane branch unit. It resolves up to NR_LANES control-flow instructions per cycle behind one register stage. Results go to the scoreboard; one resolution per cycle goes to the frontend (PC gen / BHT / BTB). An internal squash state blocks new work from the first mispredict or exception until the controller flushes.

Parameters:
NR_LANES, 2, number of parallel issue lanes; lane 0 is the oldest.
VLEN, 39, virtual address width.
TRANS_ID_W, 3, scoreboard transaction-id width.
RVC, 1, compressed ISA enabled; when 0, target bit 1 set is misaligned.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  controller flush; clears pipeline and squash state
in_ready_o  out  1  unit accepts lanes this cycle
valid_i  in  NR_LANES  lane carries a CF instruction
op_i  in  NR_LANES*2  0=BRANCH, 1=JAL, 2=JALR, 3=reserved (treated as JAL)
pc_i  in  NR_LANES*VLEN  instruction PC
base_i  in  NR_LANES*VLEN  rs1 value (JALR base)
imm_i  in  NR_LANES*VLEN  sign-extended immediate
is_compressed_i  in  NR_LANES  16-bit instruction
comp_res_i  in  NR_LANES  ALU comparison result (BRANCH only)
pred_cf_i  in  NR_LANES*3  0=NoCF, 1=Branch, 2=Jump, 3=JumpR, 4=Return
pred_addr_i  in  NR_LANES*VLEN  predicted target
trans_id_i  in  NR_LANES*TRANS_ID_W  scoreboard id
result_valid_o  out  NR_LANES  lane writeback valid
result_o  out  NR_LANES*VLEN  link value (pc+2 or pc+4)
trans_id_o  out  NR_LANES*TRANS_ID_W  registered id
ex_valid_o  out  NR_LANES  instruction-address-misaligned exception
ex_tval_o  out  NR_LANES*VLEN  faulting PC
resolved_valid_o  out  1  frontend resolution valid
resolved_pc_o  out  VLEN  resolved PC
resolved_target_o  out  VLEN  actual next PC
resolved_taken_o  out  1  branch taken / jump
resolved_mispredict_o  out  1  redirect required
resolved_cf_o  out  3  cf type for predictor update

Behaviour:
- Per lane, combinational stage: next_pc = pc + (compressed ? 2 : 4), modulo 2^VLEN.
- target = (JALR ? base : pc) + imm, modulo 2^VLEN. For JALR, target bit 0 is forced to 0.
- taken = BRANCH ? comp_res : 1.
- Mispredict, BRANCH: comp_res != (pred_cf==Branch).
- Mispredict, JALR: pred_cf==NoCF, or target != pred_addr.
- Mispredict, JAL: never.
- Exception: taken && (target[0] || (!RVC && target[1])). tval = pc.
- cf out: BRANCH gives Branch. A JALR mispredict gives JumpR unless pred_cf==Return. Otherwise cf out = pred_cf.
- Event lane = lowest-index valid lane with mispredict or exception. Lanes above the event lane are squashed: result_valid=0, ex_valid=0.
- Resolution source: the event lane if one exists. Otherwise the lowest-index valid BRANCH/JALR lane. Otherwise no resolution. Other non-event branches in the same cycle do not update the predictor.
- Resolved target = taken ? target : next_pc.
- Latency: all outputs are registered and appear exactly 1 cycle after the accepting edge.
- FSM RUN: in_ready_o=1; lanes are accepted. An accepted event moves the FSM to SQUASH on the same edge.
- FSM SQUASH: in_ready_o=0; valid_i is ignored. The output register still presents the event cycle once, then clears.
- Any state, flush_i=1: pipeline valids clear at the next edge and the FSM goes to RUN. Lanes presented in the flush cycle are dropped.
- Reset: all valid outputs 0, data outputs 0, FSM = RUN. in_ready_o=1 after reset deassertion. An asynchronous reset mid-SQUASH returns the FSM to RUN.

Optional Feature:
BRANCH_UNIT_STATS_EN
- When defined, adds outputs stat_branches_o[31:0] and stat_mispredicts_o[31:0].
- stat_branches_o counts accepted, non-squashed lanes.
- stat_mispredicts_o counts asserted resolved_mispredict_o cycles.
- Both counters are saturating, cleared by reset, and not cleared by flush_i.
- When undefined, these ports and counters do not exist.

Test Plan:
- Lane0 BRANCH, pc=0x1000, imm=0x40, comp_res=1, pred_cf=Branch -> next cycle: resolved_target=0x1040, taken=1, mispredict=0, result_valid=01.
- Lane0 JALR, base=0x2003, imm=0, pred_cf=NoCF -> target 0x2002, mispredict=1, cf=JumpR. in_ready_o=0 until flush_i; valid_i is ignored meanwhile.
- Lane0 BRANCH mispredict (comp_res=0, pred Branch) with lane1 JAL valid -> resolved_target=pc0+4, result_valid=01 (lane1 squashed).
- RVC=0, JAL pc=0x100, imm=0x2 -> ex_valid lane0=1, tval=0x100, FSM enters SQUASH. A JAL to 0x102 with RVC=1 raises no exception.
- flush_i asserted in the same cycle as a valid lane -> no outputs next cycle, FSM=RUN, in_ready_o=1.
- pc=VLEN all-ones - 1, compressed -> result_o wraps to 0x0 (after 0x7F_FFFF_FFFE + 2 for VLEN=39).
